generic_width_unpacker: RTL and testbench
=========================================

// Module: generic_width_unpacker
// PURPOSE
//  Receive-side counterpart of the generic width packer: accepts one WIDE_W word per valid/ready handshake
//  and emits it as RATIO = WIDE_W/NARROW_W narrow beats on a valid/ready output, in a configurable beat order.
//  Sits between wide datapaths (e.g. a package-provided data_b type) and narrow consumers (data_a type).
//  Zero-bubble: sustained 1 narrow beat/cycle when the source keeps up.
// PARAMETERS
//  NARROW_W  8                     narrow beat width; WIDE_W % NARROW_W == 0, WIDE_W/NARROW_W >= 2 (elab-time check)
//  WIDE_W    16                    wide word width
//  ORDER     ORDER_LSB_FIRST       beat order enum from generic_unpacker_pkg: ORDER_LSB_FIRST | ORDER_MSB_FIRST
// PORTS
//  i_clk           in   1         clock, rising edge
//  i_rst_n         in   1         asynchronous reset, active low
//  i_wide_valid    in   1         wide word valid
//  o_wide_ready    out  1         wide word accepted when valid && ready
//  i_wide_data     in   WIDE_W    wide word
//  o_narrow_valid  out  1         narrow beat valid
//  i_narrow_ready  in   1         consumer ready
//  o_narrow_data   out  NARROW_W  narrow beat
//  o_narrow_last   out  1         high on final beat of a word
// BEHAVIOUR
//  - Reset (i_rst_n low, async): state=IDLE, beat index=0, holding reg=0; o_narrow_valid=0, o_narrow_data=0,
//    o_narrow_last=0, o_wide_ready=0 while in reset; 1 from first cycle after release.
//  - FSM IDLE: o_wide_ready=1, o_narrow_valid=0. Wide handshake -> load holding reg, index=0, go SHIFT.
//  - FSM SHIFT: o_narrow_valid=1; o_narrow_data = slice[index] (LSB_FIRST: bits [index*NARROW_W +: NARROW_W];
//    MSB_FIRST: slice RATIO-1-index). Narrow handshake -> index+1.
//  - o_narrow_last = (state==SHIFT && index==RATIO-1).
//  - o_wide_ready in SHIFT = o_narrow_last && i_narrow_ready (combinational). Simultaneous last-beat handshake and
//    wide handshake: reload holding reg, index wraps to 0, stay SHIFT (no bubble). Last beat w/o new word -> IDLE.
//  - Latency: word accepted in cycle N -> first beat valid cycle N+1; word fully drained cycle N+RATIO at best.
//  - Backpressure: while i_narrow_ready=0, o_narrow_data/last/valid hold stable; index never advances.
//  - Index is ceil(log2(RATIO)) bits; wraps RATIO-1 -> 0, never exceeds RATIO-1.
//  - o_narrow_valid never drops once asserted until its handshake (AXI-stream rule).
//  - Reset mid-word: remaining beats discarded, no partial output after release.
// CONFIGURATION
//  GENERIC_UNPACKER_COUNT_EN defined: adds output o_word_count (16 bit), counts words fully emitted
//    (last-beat handshakes), saturates at 16'hFFFF, reset to 0.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  generic_unpacker_pkg: typedef enum {ORDER_LSB_FIRST, ORDER_MSB_FIRST} order_e; typedef enum {IDLE, SHIFT} state_e;
//    function calc_ratio(wide, narrow).
//  Sub-module unpacker_beat_counter: mod-RATIO counter with clear/enable, outputs index and at_last flag.
//  Top holds FSM, holding register, slice mux, optional word counter.
// TESTING
//  1 Reset then single word 16'hA55A, ready=1, LSB_FIRST -> beats 8'h5A, 8'hA5; last on 2nd; wide_ready 0 in cycle of beat 1.
//  2 ORDER=MSB_FIRST, word 16'h1234 -> beats 8'h12, 8'h34; last on 8'h34.
//  3 Back-to-back words 16'h0102, 16'h0304 with valid held -> 4 beats on 4 consecutive cycles, no bubble.
//  4 i_narrow_ready low 3 cycles mid-word -> data/valid/last stable; resumes with same beat; no loss/duplication.
//  5 NARROW_W=8, WIDE_W=32, word 32'hDEADBEEF LSB_FIRST -> EF,BE,AD,DE; index wraps to 0 for next word.
//  6 Assert i_rst_n low after first beat -> outputs 0 asynchronously; after release o_wide_ready=1, no stale beats;
//    with GENERIC_UNPACKER_COUNT_EN, o_word_count=0 after reset, =3 after three full words.

Source files
------------

// File: rtl/generic_unpacker_pkg.sv
// ---------------------------------------------------------------------------
// generic_unpacker_pkg
// Shared types and helpers for the generic width unpacker:
//   order_e     - narrow beat emission order (LSB slice first or MSB slice first)
//   state_e     - unpacker FSM states
//   calc_ratio  - number of narrow beats per wide word
// ---------------------------------------------------------------------------
package generic_unpacker_pkg;

  typedef enum logic {
    ORDER_LSB_FIRST = 1'b0,
    ORDER_MSB_FIRST = 1'b1
  } order_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int calc_ratio(input int wide, input int narrow);
    return wide / narrow;
  endfunction

endpackage

// File: rtl/unpacker_beat_counter.sv
// ---------------------------------------------------------------------------
// unpacker_beat_counter
// Modulo-RATIO beat index counter used by the width unpacker.
// Ports:
//   i_clk      in   1      clock, rising edge
//   i_rst_n    in   1      asynchronous reset, active low
//   i_clear    in   1      force index to 0 (new word loaded)
//   i_enable   in   1      advance index by one (narrow beat accepted)
//   o_index    out  IDX_W  current beat index, 0 .. RATIO-1
//   o_at_last  out  1      index is on the final beat (RATIO-1)
// ---------------------------------------------------------------------------
module unpacker_beat_counter
  import generic_unpacker_pkg::*;
#(
  parameter int RATIO = 2,
  parameter int IDX_W = $clog2(RATIO)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [IDX_W-1:0] o_index,
  output logic             o_at_last
);

  logic [IDX_W-1:0] index_q;
  logic [IDX_W-1:0] index_d;

  assign o_index   = index_q;
  assign o_at_last = (index_q == IDX_W'(RATIO - 1));

  // Wrap explicitly at RATIO-1 so non-power-of-two ratios never reach an
  // out-of-range slice.
  always_comb begin
    index_d = index_q;
    if (i_clear) begin
      index_d = '0;
    end else if (i_enable) begin
      index_d = o_at_last ? '0 : index_q + IDX_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      index_q <= '0;
    end else begin
      index_q <= index_d;
    end
  end

endmodule

// File: rtl/generic_width_unpacker.sv
// ---------------------------------------------------------------------------
// generic_width_unpacker
// Accepts one WIDE_W word per valid/ready handshake and emits it as
// RATIO = WIDE_W/NARROW_W narrow beats, LSB slice first or MSB slice first.
// A new word may be accepted in the same cycle as the last beat of the
// current one, giving a sustained rate of one narrow beat per cycle.
// Optional feature macro: GENERIC_UNPACKER_COUNT_EN adds o_word_count.
// Ports:
//   i_clk           in   1         clock, rising edge
//   i_rst_n         in   1         asynchronous reset, active low
//   i_wide_valid    in   1         wide word valid
//   o_wide_ready    out  1         wide word accepted when valid && ready
//   i_wide_data     in   WIDE_W    wide word
//   o_narrow_valid  out  1         narrow beat valid
//   i_narrow_ready  in   1         consumer ready
//   o_narrow_data   out  NARROW_W  narrow beat
//   o_narrow_last   out  1         final beat of a word
//   o_word_count    out  16        (GENERIC_UNPACKER_COUNT_EN only) words
//                                  fully emitted, saturating
// ---------------------------------------------------------------------------
module generic_width_unpacker
  import generic_unpacker_pkg::*;
#(
  parameter int     NARROW_W = 8,
  parameter int     WIDE_W   = 16,
  parameter order_e ORDER    = ORDER_LSB_FIRST
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wide_valid,
  output logic                o_wide_ready,
  input  logic [WIDE_W-1:0]   i_wide_data,
  output logic                o_narrow_valid,
  input  logic                i_narrow_ready,
  output logic [NARROW_W-1:0] o_narrow_data,
  output logic                o_narrow_last
`ifdef GENERIC_UNPACKER_COUNT_EN
  ,
  output logic [15:0]         o_word_count
`endif
);

  localparam int RATIO = calc_ratio(WIDE_W, NARROW_W);
  localparam int IDX_W = $clog2(RATIO);

  if ((WIDE_W % NARROW_W) != 0 || RATIO < 2) begin : g_bad_cfg
    $error("generic_width_unpacker: WIDE_W must be a multiple of NARROW_W with ratio >= 2");
  end

  state_e            state_q;
  state_e            state_d;
  logic [WIDE_W-1:0] hold_q;
  logic [WIDE_W-1:0] hold_d;
  logic              rst_done_q;
  logic [IDX_W-1:0]  beat_index;
  logic              at_last;
  logic              wide_hs;
  logic              narrow_hs;
  int                slice_sel;

  unpacker_beat_counter #(
    .RATIO (RATIO),
    .IDX_W (IDX_W)
  ) u_beat_counter (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (wide_hs),
    .i_enable  (narrow_hs),
    .o_index   (beat_index),
    .o_at_last (at_last)
  );

  assign o_narrow_valid = (state_q == SHIFT);
  assign o_narrow_last  = (state_q == SHIFT) && at_last;

  // rst_done_q keeps ready low while reset is held and goes high on the first
  // clock after release. In SHIFT a new word is only taken alongside the
  // accepted last beat, which is what removes the bubble between words.
  assign o_wide_ready = rst_done_q &&
                        ((state_q == IDLE) || (o_narrow_last && i_narrow_ready));
  assign wide_hs      = i_wide_valid && o_wide_ready;
  assign narrow_hs    = o_narrow_valid && i_narrow_ready;

  // Beat order only changes which slice a given index selects.
  always_comb begin
    slice_sel = int'(beat_index);
    if (ORDER == ORDER_MSB_FIRST) begin
      slice_sel = RATIO - 1 - int'(beat_index);
    end
    o_narrow_data = hold_q[slice_sel*NARROW_W +: NARROW_W];
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (wide_hs) begin
          hold_d  = i_wide_data;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (narrow_hs && at_last) begin
          if (wide_hs) begin
            hold_d = i_wide_data;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      rst_done_q <= 1'b1;
    end
  end

`ifdef GENERIC_UNPACKER_COUNT_EN
  logic [15:0] word_count_q;
  logic [15:0] word_count_d;

  assign o_word_count = word_count_q;

  // A word counts as emitted when its last beat is accepted; saturate rather
  // than wrap so the count stays meaningful on long runs.
  always_comb begin
    word_count_d = word_count_q;
    if (narrow_hs && at_last && (word_count_q != 16'hFFFF)) begin
      word_count_d = word_count_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_count_q <= '0;
    end else begin
      word_count_q <= word_count_d;
    end
  end
`endif

endmodule

// File: tb/tb_generic_width_unpacker.sv
// ---------------------------------------------------------------------------
// tb_generic_width_unpacker
// Three unpacker instances: 16->8 LSB first, 16->8 MSB first, 32->8 LSB
// first. Stimulus pushes hand-computed expected beats into per-instance
// queues; the monitor pops and compares on every narrow handshake and also
// checks that stalled beats hold steady.
// ---------------------------------------------------------------------------
module tb_generic_width_unpacker;
  import generic_unpacker_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        wideValid   [3];
  logic [31:0] wideData    [3];
  logic        wideReady   [3];
  logic        narrowValid [3];
  logic        narrowReady [3];
  logic [7:0]  narrowData  [3];
  logic        narrowLast  [3];
`ifdef GENERIC_UNPACKER_COUNT_EN
  logic [15:0] wordCount   [3];
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cycleCount  = 0;
  int hsCycles[$];

  logic [8:0] expQ0[$];
  logic [8:0] expQ1[$];
  logic [8:0] expQ2[$];

  bit         prevStall [3];
  logic [7:0] prevData  [3];
  logic       prevLast  [3];

  generic_width_unpacker #(.NARROW_W(8), .WIDE_W(16), .ORDER(ORDER_LSB_FIRST)) u_lsb16 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wide_valid(wideValid[0]), .o_wide_ready(wideReady[0]), .i_wide_data(wideData[0][15:0]),
    .o_narrow_valid(narrowValid[0]), .i_narrow_ready(narrowReady[0]),
    .o_narrow_data(narrowData[0]), .o_narrow_last(narrowLast[0])
`ifdef GENERIC_UNPACKER_COUNT_EN
    , .o_word_count(wordCount[0])
`endif
  );

  generic_width_unpacker #(.NARROW_W(8), .WIDE_W(16), .ORDER(ORDER_MSB_FIRST)) u_msb16 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wide_valid(wideValid[1]), .o_wide_ready(wideReady[1]), .i_wide_data(wideData[1][15:0]),
    .o_narrow_valid(narrowValid[1]), .i_narrow_ready(narrowReady[1]),
    .o_narrow_data(narrowData[1]), .o_narrow_last(narrowLast[1])
`ifdef GENERIC_UNPACKER_COUNT_EN
    , .o_word_count(wordCount[1])
`endif
  );

  generic_width_unpacker #(.NARROW_W(8), .WIDE_W(32), .ORDER(ORDER_LSB_FIRST)) u_lsb32 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wide_valid(wideValid[2]), .o_wide_ready(wideReady[2]), .i_wide_data(wideData[2]),
    .o_narrow_valid(narrowValid[2]), .i_narrow_ready(narrowReady[2]),
    .o_narrow_data(narrowData[2]), .o_narrow_last(narrowLast[2])
`ifdef GENERIC_UNPACKER_COUNT_EN
    , .o_word_count(wordCount[2])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  function automatic int ratioOf(input int inst);
    return (inst == 2) ? 4 : 2;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic pushExp(input int inst, input logic [8:0] e);
    case (inst)
      0:       expQ0.push_back(e);
      1:       expQ1.push_back(e);
      default: expQ2.push_back(e);
    endcase
  endtask

  task automatic popExp(input int inst, output bit have, output logic [8:0] e);
    have = 1'b0;
    e    = '0;
    case (inst)
      0:       if (expQ0.size() > 0) begin e = expQ0.pop_front(); have = 1'b1; end
      1:       if (expQ1.size() > 0) begin e = expQ1.pop_front(); have = 1'b1; end
      default: if (expQ2.size() > 0) begin e = expQ2.pop_front(); have = 1'b1; end
    endcase
  endtask

  // Offer one wide word; expBeats holds the expected beats in emission order,
  // first beat in bits [7:0]. keep leaves valid high for a back-to-back word.
  task automatic applyStimulus(input int inst, input logic [31:0] word,
                               input logic [31:0] expBeats, input bit keep);
    bit ok = 1'b0;
    wideValid[inst] = 1'b1;
    wideData[inst]  = word;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (wideReady[inst] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      for (int b = 0; b < ratioOf(inst); b++) begin
        pushExp(inst, {(b == ratioOf(inst) - 1), expBeats[b*8 +: 8]});
      end
      @(posedge clk);
      #1;
      if (!keep) wideValid[inst] = 1'b0;
    end else begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wide_accept_%0d: ready never seen for word %h, required within 50 cycles", inst, word);
      wideValid[inst] = 1'b0;
    end
  endtask

  task automatic checkOutput(input int inst);
    logic       v, r, l;
    logic [7:0] d;
    logic [8:0] e;
    bit         have;
    v = narrowValid[inst];
    r = narrowReady[inst];
    l = narrowLast[inst];
    d = narrowData[inst];
    if (prevStall[inst]) begin
      vectors++;
      if (v !== 1'b1 || d !== prevData[inst] || l !== prevLast[inst]) begin
        miscompares++;
        $display("[TB] FAIL hold_%0d: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                 inst, v, d, l, prevData[inst], prevLast[inst]);
      end
    end
    if (v === 1'b1 && r === 1'b1) begin
      popExp(inst, have, e);
      vectors++;
      if (!have) begin
        miscompares++;
        $display("[TB] FAIL unexpected_beat_%0d: got data=%h last=%b, required no beat", inst, d, l);
      end else if ({l, d} !== e) begin
        miscompares++;
        $display("[TB] FAIL beat_%0d: got data=%h last=%b, required data=%h last=%b",
                 inst, d, l, e[7:0], e[8]);
      end
      if (inst == 0) hsCycles.push_back(cycleCount);
    end
    prevStall[inst] = (v === 1'b1) && (r !== 1'b1);
    prevData[inst]  = d;
    prevLast[inst]  = l;
  endtask

  // Monitor: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) prevStall[i] = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) checkOutput(i);
    end
  end

  initial begin
    int start;
    for (int i = 0; i < 3; i++) begin
      wideValid[i]   = 1'b0;
      wideData[i]    = '0;
      narrowReady[i] = 1'b1;
    end
    rst_n = 1'b0;

    // Reset state
    #3;
    checkValue("reset_valid", 32'(narrowValid[0]), 32'h0);
    checkValue("reset_data",  32'(narrowData[0]),  32'h0);
    checkValue("reset_last",  32'(narrowLast[0]),  32'h0);
    checkValue("reset_wide_ready", 32'(wideReady[2]), 32'h0);
    #19 rst_n = 1'b1;
    @(negedge clk);
    checkValue("idle_wide_ready", 32'(wideReady[0]), 32'h1);
    checkValue("idle_valid",      32'(narrowValid[0]), 32'h0);
    @(posedge clk); #1;

    // Single word, LSB first: 5A then A5 (last)
    applyStimulus(0, 32'h0000_A55A, 32'h0000_A55A, 1'b0);
    @(negedge clk);
    checkValue("first_beat_latency", 32'(narrowValid[0]), 32'h1);
    checkValue("ready_during_beat0", 32'(wideReady[0]), 32'h0);
    checkValue("last_on_beat0",      32'(narrowLast[0]), 32'h0);
    repeat (3) @(posedge clk); #1;

    // MSB first: 12 then 34 (last)
    applyStimulus(1, 32'h0000_1234, 32'h0000_3412, 1'b0);
    repeat (3) @(posedge clk); #1;

    // Back-to-back words with valid held: four beats, no bubble
    start = hsCycles.size();
    applyStimulus(0, 32'h0000_0102, 32'h0000_0102, 1'b1);
    applyStimulus(0, 32'h0000_0304, 32'h0000_0304, 1'b0);
    repeat (5) @(posedge clk); #1;
    checkValue("b2b_beat_count", 32'(hsCycles.size() - start), 32'd4);
    if (hsCycles.size() >= start + 4) begin
      for (int k = 1; k < 4; k++) begin
        checkValue("b2b_gap", 32'(hsCycles[start+k] - hsCycles[start+k-1]), 32'd1);
      end
    end

    // Backpressure for 3 cycles on the second beat
    applyStimulus(0, 32'h0000_C3D4, 32'h0000_C3D4, 1'b0);
    @(posedge clk); #1;
    narrowReady[0] = 1'b0;
    repeat (3) @(posedge clk);
    checkValue("stall_last", 32'(narrowLast[0]), 32'h1);
    #1 narrowReady[0] = 1'b1;
    repeat (3) @(posedge clk); #1;

    // 32->8: EF,BE,AD,DE then index wraps for 01,02,03,04
    applyStimulus(2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    applyStimulus(2, 32'h0403_0201, 32'h0403_0201, 1'b0);
    repeat (6) @(posedge clk); #1;

    // Reset after first beat: remaining beat discarded
    applyStimulus(0, 32'h0000_5AA5, 32'h0000_5AA5, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    expQ0.delete();
    #1;
    checkValue("midreset_valid", 32'(narrowValid[0]), 32'h0);
    checkValue("midreset_data",  32'(narrowData[0]),  32'h0);
    checkValue("midreset_last",  32'(narrowLast[0]),  32'h0);
    checkValue("midreset_ready", 32'(wideReady[0]),   32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkValue("post_reset_ready", 32'(wideReady[0]),   32'h1);
    checkValue("post_reset_valid", 32'(narrowValid[0]), 32'h0);
    checkValue("post_reset_data",  32'(narrowData[0]),  32'h0);
`ifdef GENERIC_UNPACKER_COUNT_EN
    checkValue("count_after_reset", 32'(wordCount[0]), 32'd0);
`endif
    @(posedge clk); #1;
    applyStimulus(0, 32'h0000_1111, 32'h0000_1111, 1'b1);
    applyStimulus(0, 32'h0000_2222, 32'h0000_2222, 1'b1);
    applyStimulus(0, 32'h0000_3333, 32'h0000_3333, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
`ifdef GENERIC_UNPACKER_COUNT_EN
    checkValue("count_three_words", 32'(wordCount[0]), 32'd3);
`endif

    // Drain: every expected beat must have appeared
    for (int t = 0; t < 100; t++) begin
      if (expQ0.size() + expQ1.size() + expQ2.size() == 0) break;
      @(negedge clk);
    end
    checkValue("leftover_beats", 32'(expQ0.size() + expQ1.size() + expQ2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
